// File: rtl/decode_issue_stage_if.sv
// Handshake and data bundle between fetch, the decode/issue stage, the control store and execute.
// The stage uses the slave view; the surrounding pipeline uses the master view.
interface decode_issue_stage_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            flush;
    logic [10:0]     cs_addr;
    logic [16:0]     cs_data;
    logic            out_valid;
    logic            out_ready;
    logic [16:0]     out_ctrl;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [XLEN-1:0] out_imm;
    logic [XLEN-1:0] out_pc;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, in_pc, flush, cs_data, out_ready,
        input  in_ready, cs_addr, out_valid, out_ctrl, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, in_pc, flush, cs_data, out_ready,
        output in_ready, cs_addr, out_valid, out_ctrl, out_rd, out_rs1, out_rs2,
               out_imm, out_pc, out_illegal
    );
endinterface

// File: rtl/decode_issue_stage.sv
// RV64I decode front end: control-store addressing, legality squash, immediate
// generation and a two-entry (main + skid) output buffer so in_ready is a flop.
module decode_issue_stage #(
    parameter int XLEN = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    decode_issue_stage_if.slave bus
);
    typedef struct packed {
        logic [16:0]     ctrl;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } bundle_t;

    function automatic logic is_legal(input logic [31:0] instr);
        logic [2:0] f3;
        logic       ok;
        f3 = instr[14:12];
        ok = 1'b0;
        case (instr[6:0])
            7'b0110111, 7'b0010111, 7'b1101111,
            7'b0010011, 7'b0110011:             ok = 1'b1;
            7'b1100111:                         ok = (f3 == 3'b000);
            7'b1100011:                         ok = (f3 != 3'b010) && (f3 != 3'b011);
            7'b0000011:                         ok = (f3 != 3'b111);
            7'b0100011:                         ok = !f3[2];
            7'b0011011, 7'b0111011:             ok = (f3 == 3'b000) || (f3 == 3'b001) ||
                                                     (f3 == 3'b101);
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [XLEN-1:0] gen_imm(input logic [31:0] i);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (i[6:0])
            7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111:
                imm = {{(XLEN-12){i[31]}}, i[31:20]};
            7'b0100011:
                imm = {{(XLEN-12){i[31]}}, i[31:25], i[11:7]};
            7'b1100011:
                imm = {{(XLEN-13){i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            7'b0110111, 7'b0010111:
                imm = {{(XLEN-32){i[31]}}, i[31:12], 12'b0};
            7'b1101111:
                imm = {{(XLEN-21){i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default:
                imm = '0;
        endcase
        return imm;
    endfunction

    bundle_t main_reg;
    bundle_t skid_reg;
    logic    main_valid_reg;
    logic    skid_valid_reg;
    bundle_t new_bundle;
    logic    legal;
    logic    accept;
    logic    drain;

    // Control store is addressed from the raw instruction, independent of in_valid.
    assign bus.cs_addr = {bus.in_instr[6:0], bus.in_instr[14:12], bus.in_instr[30]};

    assign legal  = is_legal(bus.in_instr);
    assign accept = bus.in_valid & ~skid_valid_reg;
    assign drain  = main_valid_reg & bus.out_ready;

    always_comb begin
        new_bundle         = '0;
        new_bundle.ctrl    = legal ? bus.cs_data : 17'd0;
        new_bundle.rd      = bus.in_instr[11:7];
        new_bundle.rs1     = bus.in_instr[19:15];
        new_bundle.rs2     = bus.in_instr[24:20];
        new_bundle.imm     = gen_imm(bus.in_instr);
        new_bundle.pc      = bus.in_pc;
        new_bundle.illegal = ~legal;
    end

    // Accept is impossible while skid is full, so the two branches never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (bus.flush) begin
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else if (skid_valid_reg) begin
            if (drain) begin
                main_reg       <= skid_reg;
                skid_valid_reg <= 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_reg || drain) begin
                main_reg       <= new_bundle;
                main_valid_reg <= 1'b1;
            end else begin
                skid_reg       <= new_bundle;
                skid_valid_reg <= 1'b1;
            end
        end else if (drain) begin
            main_valid_reg <= 1'b0;
        end
    end

    assign bus.in_ready    = ~skid_valid_reg;
    assign bus.out_valid   = main_valid_reg;
    assign bus.out_ctrl    = main_reg.ctrl;
    assign bus.out_rd      = main_reg.rd;
    assign bus.out_rs1     = main_reg.rs1;
    assign bus.out_rs2     = main_reg.rs2;
    assign bus.out_imm     = main_reg.imm;
    assign bus.out_pc      = main_reg.pc;
    assign bus.out_illegal = main_reg.illegal;
endmodule
